// File: rtl/io_po_cko_cfg_pkg.sv
// -----------------------------------------------------------------------------
// io_po_cko_cfg_pkg
// Shared definitions for the po_cko configuration loader:
//   - PO_CKO_CFG_BITS : feedthrough memory width of the pad tile
//                       (7 scan-FF bits + 1 output-mux select)
//   - cfg_state_t     : loader FSM states
//   - cnt_width()     : width of the beat counter, which must hold 0..n
// Optional feature macro: CFG_LOADER_PARITY_EN (adds the CHECK state).
// -----------------------------------------------------------------------------
package io_po_cko_cfg_pkg;

  localparam int PO_CKO_CFG_BITS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
`ifdef CFG_LOADER_PARITY_EN
    CHECK  = 2'd2,
`endif
    COMMIT = 2'd3
  } cfg_state_t;

  // The counter has to represent every value from 0 up to n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/io_po_cko_cfg_loader_if.sv
// -----------------------------------------------------------------------------
// io_po_cko_cfg_loader_if
// Serial configuration beat channel (valid/ready).
//   cfg_valid  : source -> loader, beat is valid
//   cfg_ready  : loader -> source, beat can be accepted
//   cfg_bit    : source -> loader, configuration bit
//   cfg_last   : source -> loader, final beat of a frame
//   cfg_parity : source -> loader, even-parity bit sampled with the last beat
//                (only present when CFG_LOADER_PARITY_EN is defined)
// Modports: master (beat source), slave (loader).
// -----------------------------------------------------------------------------
interface io_po_cko_cfg_loader_if;

  logic cfg_valid;
  logic cfg_ready;
  logic cfg_bit;
  logic cfg_last;
`ifdef CFG_LOADER_PARITY_EN
  logic cfg_parity;
`endif

  modport master (
    output cfg_valid,
    output cfg_bit,
    output cfg_last,
`ifdef CFG_LOADER_PARITY_EN
    output cfg_parity,
`endif
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_bit,
    input  cfg_last,
`ifdef CFG_LOADER_PARITY_EN
    input  cfg_parity,
`endif
    output cfg_ready
  );

endinterface

// File: rtl/io_po_cko_cfg_shadow.sv
// -----------------------------------------------------------------------------
// io_po_cko_cfg_shadow
// Shadow register that assembles a frame one bit per beat, plus the beat
// counter that selects the write index.
//   clk_i     : configuration clock
//   rst_ni    : asynchronous active-low reset
//   wr_en_i   : accepted beat; writes shadow[cnt] and increments cnt
//   wr_bit_i  : bit to write
//   clr_i     : discard the frame (cnt and shadow back to zero); wins over write
//   shadow_o  : assembled frame, index 0 = first beat
//   cnt_o     : number of beats stored so far
// -----------------------------------------------------------------------------
module io_po_cko_cfg_shadow
  import io_po_cko_cfg_pkg::*;
#(
  parameter int NUM_BITS = PO_CKO_CFG_BITS,
  parameter int CW       = cnt_width(NUM_BITS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_en_i,
  input  logic                wr_bit_i,
  input  logic                clr_i,
  output logic [0:NUM_BITS-1] shadow_o,
  output logic [CW-1:0]       cnt_o
);

  logic [CW-1:0] cnt_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BITS; gi++) begin : g_bit
      logic bit_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          bit_q <= 1'b0;
        end else if (clr_i) begin
          bit_q <= 1'b0;
        end else if (wr_en_i && (cnt_q == CW'(gi))) begin
          bit_q <= wr_bit_i;
        end
      end
      assign shadow_o[gi] = bit_q;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (wr_en_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/io_po_cko_cfg_loader.sv
// -----------------------------------------------------------------------------
// io_po_cko_cfg_loader
// Collects a serial configuration frame, validates its length (and parity when
// CFG_LOADER_PARITY_EN is defined) and only then commits it to the true and
// complement feedthrough buses of the po_cko pad tile.
//   prog_clk             : configuration clock
//   prog_reset_n         : asynchronous active-low reset
//   cfg                  : beat channel (slave side)
//   err_clr              : clears cfg_err (a simultaneous new error wins)
//   feedthrough_mem_out  : committed configuration, index 0 = first beat
//   feedthrough_mem_outb : bitwise complement of feedthrough_mem_out
//   commit_done          : one-cycle pulse when a frame is committed
//   cfg_err              : sticky frame error
//   busy                 : frame in progress
// Optional feature macro: CFG_LOADER_PARITY_EN.
// -----------------------------------------------------------------------------
module io_po_cko_cfg_loader
  import io_po_cko_cfg_pkg::*;
#(
  parameter int NUM_BITS = PO_CKO_CFG_BITS
) (
  input  logic                   prog_clk,
  input  logic                   prog_reset_n,
  io_po_cko_cfg_loader_if.slave  cfg,
  input  logic                   err_clr,
  output logic [0:NUM_BITS-1]    feedthrough_mem_out,
  output logic [0:NUM_BITS-1]    feedthrough_mem_outb,
  output logic                   commit_done,
  output logic                   cfg_err,
  output logic                   busy
);

  localparam int CW = cnt_width(NUM_BITS);

  // Where a correctly sized frame goes after its last beat.
`ifdef CFG_LOADER_PARITY_EN
  localparam cfg_state_t FRAME_DONE = CHECK;
`else
  localparam cfg_state_t FRAME_DONE = COMMIT;
`endif

  cfg_state_t          state_q, state_d;
  logic [CW-1:0]       cnt;
  logic [0:NUM_BITS-1] shadow;
  logic                accept;
  logic                wr_en_d, clr_d, err_set_d, commit_d;
  logic [0:NUM_BITS-1] out_q, outb_q;
  logic                commit_done_q, cfg_err_q, busy_q;

  // Ready comes from the registered state; it is also held low while the
  // reset is asserted so no beat can slip in during reset.
  assign cfg.cfg_ready = prog_reset_n && ((state_q == IDLE) || (state_q == SHIFT));
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;

`ifdef CFG_LOADER_PARITY_EN
  logic parity_q;
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      parity_q <= 1'b0;
    end else if (accept && cfg.cfg_last) begin
      parity_q <= cfg.cfg_parity;
    end
  end
`endif

  io_po_cko_cfg_shadow #(
    .NUM_BITS (NUM_BITS),
    .CW       (CW)
  ) u_shadow (
    .clk_i    (prog_clk),
    .rst_ni   (prog_reset_n),
    .wr_en_i  (wr_en_d),
    .wr_bit_i (cfg.cfg_bit),
    .clr_i    (clr_d),
    .shadow_o (shadow),
    .cnt_o    (cnt)
  );

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    clr_d     = 1'b0;
    err_set_d = 1'b0;
    commit_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cfg.cfg_last && (NUM_BITS > 1)) begin
            err_set_d = 1'b1;
            clr_d     = 1'b1;
          end else begin
            wr_en_d = 1'b1;
            state_d = cfg.cfg_last ? FRAME_DONE : SHIFT;
          end
        end
      end
      SHIFT: begin
        if (accept) begin
          // cnt holds the beats already stored, so this beat is number cnt+1.
          if (cnt >= CW'(NUM_BITS)) begin
            err_set_d = 1'b1;
            clr_d     = 1'b1;
            state_d   = IDLE;
          end else if (cfg.cfg_last) begin
            if (cnt == CW'(NUM_BITS - 1)) begin
              wr_en_d = 1'b1;
              state_d = FRAME_DONE;
            end else begin
              err_set_d = 1'b1;
              clr_d     = 1'b1;
              state_d   = IDLE;
            end
          end else begin
            wr_en_d = 1'b1;
          end
        end
      end
`ifdef CFG_LOADER_PARITY_EN
      CHECK: begin
        if ((^shadow) ^ parity_q) begin
          err_set_d = 1'b1;
          clr_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = COMMIT;
        end
      end
`endif
      COMMIT: begin
        commit_d = 1'b1;
        clr_d    = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q       <= IDLE;
      out_q         <= '0;
      outb_q        <= '1;
      commit_done_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= (state_d != IDLE);
      commit_done_q <= commit_d;
      if (commit_d) begin
        out_q  <= shadow;
        outb_q <= ~shadow;
      end
      if (err_set_d) begin
        cfg_err_q <= 1'b1;
      end else if (err_clr) begin
        cfg_err_q <= 1'b0;
      end
    end
  end

  assign feedthrough_mem_out  = out_q;
  assign feedthrough_mem_outb = outb_q;
  assign commit_done          = commit_done_q;
  assign cfg_err              = cfg_err_q;
  assign busy                 = busy_q;

endmodule
